matmul_seq_ctrl: RTL and testbench
==================================

Name: matmul_seq_ctrl

Overview:
- Sequencer for the single-MAC matmul datapath: C[n x q] = A[n x m] * B[m x q], runtime dims 1..M.
- Issues operand read addresses (i,k)/(k,j) one k-step per cycle, marks first/last k to the MAC accumulator, and emits a result write (i,j) aligned to MAC pipeline latency.
- Sits between the host start/done handshake and the operand/result matrix memories plus MAC.

Parameters:
- M, 32, maximum matrix dimension (square storage M x M).
- MAC_LAT, 3, cycles from operand issue to MAC result valid (>=1).
- IDX_W, $clog2(M), row/col index width.
- DIM_W, $clog2(M+1), dimension field width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- abort  in  1  cancel current job
- dim_n  in  DIM_W  rows of A
- dim_m  in  DIM_W  cols of A = rows of B
- dim_q  in  DIM_W  cols of B
- busy  out  1  high from cycle after start acceptance until done/err/abort
- done  out  1  one-cycle pulse at successful completion
- err  out  1  one-cycle pulse on illegal dims
- rd_en  out  1  operand read/issue valid
- a_row, a_col  out  IDX_W each  A address (i,k)
- b_row, b_col  out  IDX_W each  B address (k,j)
- mac_first  out  1  with rd_en when k==0 (accumulator load, not add)
- mac_last  out  1  with rd_en when k==m-1
- wr_en  out  1  result write strobe
- wr_row, wr_col  out  IDX_W each  result address (i,j)

Behaviour:
- Reset: state IDLE; all outputs 0; dims, counters and write pipe cleared.
- States: IDLE, RUN, DRAIN, DONE, ERR.
- IDLE: start=1 latches dims (cycle 0). If any dim is 0 or >M -> ERR; else RUN, i=j=k=0.
- ERR: err=1 for one cycle, busy=1, rd_en=0; -> IDLE.
- RUN: rd_en=1 every cycle, no bubbles. k increments; on k==m-1, k wraps to 0 and j increments; on j==q-1, j wraps to 0 and i increments. The issue with i==n-1, j==q-1, k==m-1 is the final one -> DRAIN. Issue cycles 1..n*q*m.
- Write pipe: a MAC_LAT-deep shift register carries (valid=mac_last, i, j). wr_en/wr_row/wr_col appear exactly MAC_LAT cycles after the matching mac_last issue.
- DRAIN: rd_en=0; wait until pipe empty (last wr_en at cycle n*q*m+MAC_LAT) -> DONE.
- DONE: done=1 one cycle (cycle n*q*m+MAC_LAT+1), busy=0; -> IDLE.
- m==1: mac_first and mac_last both high on every issue.
- start while not IDLE: ignored. Dim inputs changing mid-job: ignored (latched copy used).
- abort (non-IDLE): next cycle IDLE, pipe flushed, rd_en/wr_en=0, no done/err. abort in IDLE: no effect. abort and start same cycle in IDLE: abort wins, job not accepted.
- reset mid-job: same as abort plus full reset values.
- Address outputs hold last value when rd_en/wr_en=0 (don't-care for consumers).

Optional Feature:
- MATMUL_SEQ_CTRL_PERF_EN: adds output cyc_cnt [31:0], cleared on job acceptance, +1 each busy cycle, frozen after done/err/abort; observed value for a legal job is n*q*m+MAC_LAT+1.
- Without macro: port and counter absent; no other behaviour change.

Decomposition:
- matmul_pkg: DATA_WIDTH (16), M (32), IDX_W, DIM_W, accumulator element type (signed, 2*DATA_WIDTH+$clog2(M) bits), state enum.
- Sub-module matmul_wr_pipe: parameterised MAC_LAT-deep valid+index delay line with synchronous flush.

Test Plan:
- 2x3 * 3x2, MAC_LAT=3 -> 12 issues, cycles 1..12; wr_en cycles 6,9,12,15 at (0,0),(0,1),(1,0),(1,1); done cycle 16; bench-modelled MAC result matches software reference.
- 32x32 * 32x32 -> 32768 issues, 1024 writes each (i,j) once in row-major order; done cycle 32772.
- dim_m=1, 4x1 * 1x4 -> mac_first==mac_last==rd_en every issue; 16 writes; done cycle 20.
- dim_n=0, and separately dim_q=33 -> err pulse cycle 1, zero rd_en/wr_en, no done.
- abort at cycle 7 of 2x3*3x2 job -> no wr_en/done afterwards; immediate new start runs cleanly to completion.
- start pulsed during RUN and dims changed mid-job -> ignored; results and timing of original job unchanged.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and constants for the single-MAC matmul sequencer.
package matmul_pkg;

    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned M          = 32;
    localparam int unsigned IDX_W      = $clog2(M);
    localparam int unsigned DIM_W      = $clog2(M + 1);

    // Accumulator wide enough for M products of two DATA_WIDTH operands
    typedef logic signed [2*DATA_WIDTH+$clog2(M)-1:0] acc_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE,
        S_ERR
    } state_t;

endpackage

// File: rtl/matmul_wr_pipe.sv
// Result-write delay line: carries (valid, row, col) DEPTH cycles to line up
// with the MAC pipeline. Synchronous flush drops everything in flight.
module matmul_wr_pipe #(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned IDX_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_row,
    input  logic [IDX_W-1:0] in_col,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_row,
    output logic [IDX_W-1:0] out_col,
    output logic             pending
);

    logic [DEPTH-1:0]            vld_q;
    logic [DEPTH-1:0][IDX_W-1:0] row_q;
    logic [DEPTH-1:0][IDX_W-1:0] col_q;
    logic [DEPTH:0]              vld_chain;
    logic [DEPTH:0][IDX_W-1:0]   row_chain;
    logic [DEPTH:0][IDX_W-1:0]   col_chain;

    // Input joins at the bottom of the chain; each register takes its lower neighbour
    assign vld_chain = {vld_q, in_valid};
    assign row_chain = {row_q, in_row};
    assign col_chain = {col_q, in_col};

    // Shift one stage per cycle, cleared on reset or flush
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            vld_q <= '0;
            row_q <= '0;
            col_q <= '0;
        end else begin
            vld_q <= vld_chain[DEPTH-1:0];
            row_q <= row_chain[DEPTH-1:0];
            col_q <= col_chain[DEPTH-1:0];
        end
    end

    assign out_valid = vld_q[DEPTH-1];
    assign out_row   = row_q[DEPTH-1];
    assign out_col   = col_q[DEPTH-1];
    // Anything still in flight behind the output stage (shift drops the MSB)
    assign pending   = |(vld_q << 1);

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Matmul sequencer: walks (i,j,k) issuing operand addresses one k-step per
// cycle, flags first/last k to the MAC, and emits aligned result writes.
// Optional MATMUL_SEQ_CTRL_PERF_EN adds the cyc_cnt job-length counter.
module matmul_seq_ctrl #(
    parameter int unsigned M       = 32,
    parameter int unsigned MAC_LAT = 3,
    parameter int unsigned IDX_W   = $clog2(M),
    parameter int unsigned DIM_W   = $clog2(M + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [DIM_W-1:0] dim_n,
    input  logic [DIM_W-1:0] dim_m,
    input  logic [DIM_W-1:0] dim_q,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             rd_en,
    output logic [IDX_W-1:0] a_row,
    output logic [IDX_W-1:0] a_col,
    output logic [IDX_W-1:0] b_row,
    output logic [IDX_W-1:0] b_col,
    output logic             mac_first,
    output logic             mac_last,
    output logic             wr_en,
    output logic [IDX_W-1:0] wr_row,
    output logic [IDX_W-1:0] wr_col
`ifdef MATMUL_SEQ_CTRL_PERF_EN
    ,
    output logic [31:0]      cyc_cnt
`endif
);

    import matmul_pkg::*;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] i_q, j_q, k_q;
    logic [IDX_W-1:0] n_last, m_last, q_last;
    logic             accept, dims_ok, flush, pending;
    logic             i_end, j_end, k_end, final_issue;

    assign dims_ok = (dim_n != '0) && (dim_n <= DIM_W'(M)) &&
                     (dim_m != '0) && (dim_m <= DIM_W'(M)) &&
                     (dim_q != '0) && (dim_q <= DIM_W'(M));

    assign flush       = abort && (state != S_IDLE);
    assign i_end       = (i_q == n_last);
    assign j_end       = (j_q == q_last);
    assign k_end       = (k_q == m_last);
    assign final_issue = i_end && j_end && k_end;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state and control outputs; abort overrides every transition
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        rd_en     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    accept    = 1'b1;
                    state_nxt = dims_ok ? S_RUN : S_ERR;
                end
            end
            S_RUN: begin
                busy  = 1'b1;
                rd_en = 1'b1;
                if (final_issue) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (!pending) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            S_ERR: begin
                busy      = 1'b1;
                err       = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (flush) state_nxt = S_IDLE;
    end

    // Dimension latch and i/j/k loop counters; counters hold after the final issue
    always_ff @(posedge clk) begin
        if (reset) begin
            i_q    <= '0;
            j_q    <= '0;
            k_q    <= '0;
            n_last <= '0;
            m_last <= '0;
            q_last <= '0;
        end else if (accept) begin
            i_q    <= '0;
            j_q    <= '0;
            k_q    <= '0;
            n_last <= IDX_W'(dim_n - DIM_W'(1));
            m_last <= IDX_W'(dim_m - DIM_W'(1));
            q_last <= IDX_W'(dim_q - DIM_W'(1));
        end else if (state == S_RUN && !final_issue) begin
            if (k_end) begin
                k_q <= '0;
                if (j_end) begin
                    j_q <= '0;
                    i_q <= i_q + 1'b1;
                end else begin
                    j_q <= j_q + 1'b1;
                end
            end else begin
                k_q <= k_q + 1'b1;
            end
        end
    end

    assign a_row     = i_q;
    assign a_col     = k_q;
    assign b_row     = k_q;
    assign b_col     = j_q;
    assign mac_first = rd_en && (k_q == '0);
    assign mac_last  = rd_en && k_end;

    matmul_wr_pipe #(
        .DEPTH (MAC_LAT),
        .IDX_W (IDX_W)
    ) u_wr_pipe (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (mac_last),
        .in_row    (i_q),
        .in_col    (j_q),
        .out_valid (wr_en),
        .out_row   (wr_row),
        .out_col   (wr_col),
        .pending   (pending)
    );

`ifdef MATMUL_SEQ_CTRL_PERF_EN
    // Job length: acceptance cycle counts as 1, then +1 per busy cycle; frozen on abort
    always_ff @(posedge clk) begin
        if (reset)                cyc_cnt <= '0;
        else if (accept)          cyc_cnt <= 32'd1;
        else if (busy && !flush)  cyc_cnt <= cyc_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Scoreboard bench for matmul_seq_ctrl: stimulus pushes expected issues,
// writes and done/err events; a negedge monitor pops and compares them.
module tb_matmul_seq_ctrl;

    import matmul_pkg::*;

    localparam int unsigned MAC_LAT = 3;

    typedef struct {
        int                   cyc;
        logic [4*IDX_W+1:0]   v;
    } iss_t;

    typedef struct {
        int   cyc;
        int   row;
        int   col;
        acc_t c;
    } wr_t;

    typedef struct {
        int kind;   // 0 = done, 1 = err
        int cyc;
        int perf;
    } ev_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [DIM_W-1:0] dim_n = '0, dim_m = '0, dim_q = '0;
    logic             busy, done, err, rd_en, mac_first, mac_last, wr_en;
    logic [IDX_W-1:0] a_row, a_col, b_row, b_col, wr_row, wr_col;
`ifdef MATMUL_SEQ_CTRL_PERF_EN
    logic [31:0]      cyc_cnt;
`endif

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    iss_t exp_iss[$];
    wr_t  exp_wr[$];
    ev_t  ev_q[$];
    acc_t prod_q[$];
    acc_t acc, prod;
    iss_t ie;
    wr_t  we;
    ev_t  ee;
    int   a_mat[M][M];
    int   b_mat[M][M];

    matmul_seq_ctrl #(
        .M       (M),
        .MAC_LAT (MAC_LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .dim_n     (dim_n),
        .dim_m     (dim_m),
        .dim_q     (dim_q),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rd_en     (rd_en),
        .a_row     (a_row),
        .a_col     (a_col),
        .b_row     (b_row),
        .b_col     (b_col),
        .mac_first (mac_first),
        .mac_last  (mac_last),
        .wr_en     (wr_en),
        .wr_row    (wr_row),
        .wr_col    (wr_col)
`ifdef MATMUL_SEQ_CTRL_PERF_EN
        ,
        .cyc_cnt   (cyc_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, expv);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s cyc=%0d got=unexpected expected=none", name, cyc);
    endtask

    // Monitor: pops expectations whenever the DUT presents an issue, write or event
    always @(negedge clk) begin
        if (!reset) begin
            if (rd_en) begin
                prod = acc_t'(a_mat[a_row][a_col]) * acc_t'(b_mat[b_row][b_col]);
                acc  = mac_first ? prod : acc + prod;
                if (mac_last) prod_q.push_back(acc);
                if (exp_iss.size() == 0) fail_now("issue_unexpected");
                else begin
                    ie = exp_iss.pop_front();
                    chk("issue_cycle", 64'(cyc), 64'(ie.cyc));
                    chk("issue_addr", 64'({a_row, a_col, b_row, b_col, mac_first, mac_last}), 64'(ie.v));
                end
            end
            if (wr_en) begin
                if (exp_wr.size() == 0) fail_now("write_unexpected");
                else begin
                    we = exp_wr.pop_front();
                    chk("write_cycle", 64'(cyc), 64'(we.cyc));
                    chk("write_addr", 64'({wr_row, wr_col}), 64'({IDX_W'(we.row), IDX_W'(we.col)}));
                    if (prod_q.size() == 0) fail_now("mac_result_missing");
                    else chk("mac_result", 64'(prod_q.pop_front()), 64'(we.c));
                end
            end
            if (done || err) begin
                if (ev_q.size() == 0) fail_now("event_unexpected");
                else begin
                    ee = ev_q.pop_front();
                    chk("event_cycle", 64'(cyc), 64'(ee.cyc));
                    chk("event_flags", 64'({done, err, busy}), (ee.kind == 0) ? 64'(3'b100) : 64'(3'b011));
`ifdef MATMUL_SEQ_CTRL_PERF_EN
                    if (ee.kind == 0) chk("perf_count", 64'(cyc_cnt), 64'(ee.perf));
`endif
                end
            end
        end
    end

    // Pushes the expected response of one job, then pulses start for one cycle.
    // abort_at > 0 limits expectations to what survives an abort in that cycle.
    task automatic launch(input int n, input int m, input int q, input int done_rel, input int abort_at);
        int   base, idx;
        acc_t c;
        logic legal;
        base  = cyc;
        legal = (n >= 1 && n <= M && m >= 1 && m <= M && q >= 1 && q <= M);
        if (!legal) begin
            ev_q.push_back('{1, base + 1, 0});
        end else begin
            idx = 0;
            for (int i = 0; i < n; i++) begin
                for (int j = 0; j < q; j++) begin
                    c = '0;
                    for (int k = 0; k < m; k++) c += acc_t'(a_mat[i][k]) * acc_t'(b_mat[k][j]);
                    for (int k = 0; k < m; k++) begin
                        idx++;
                        if (abort_at == 0 || idx <= abort_at)
                            exp_iss.push_back('{base + idx,
                                {IDX_W'(i), IDX_W'(k), IDX_W'(k), IDX_W'(j), (k == 0), (k == m - 1)}});
                        if (k == m - 1 && (abort_at == 0 || idx + int'(MAC_LAT) <= abort_at))
                            exp_wr.push_back('{base + idx + int'(MAC_LAT), i, j, c});
                    end
                end
            end
            if (abort_at == 0) ev_q.push_back('{0, base + done_rel, n * q * m + int'(MAC_LAT) + 1});
        end
        dim_n = DIM_W'(n);
        dim_m = DIM_W'(m);
        dim_q = DIM_W'(q);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while ((exp_iss.size() + exp_wr.size() + ev_q.size()) != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_complete"}, 64'(exp_iss.size() + exp_wr.size() + ev_q.size()), 64'(0));
        exp_iss.delete();
        exp_wr.delete();
        ev_q.delete();
    endtask

    initial begin
        for (int r = 0; r < int'(M); r++) begin
            for (int s = 0; s < int'(M); s++) begin
                a_mat[r][s] = ((r * 7 + s * 3) % 11) - 5;
                b_mat[r][s] = ((r * 5 + s * 13) % 17) - 8;
            end
        end
        acc = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs",
            64'({busy, done, err, rd_en, mac_first, mac_last, wr_en, a_row, a_col, b_row, b_col, wr_row, wr_col}),
            64'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        // 2x3 * 3x2: writes at 6,9,12,15, done at 16
        launch(2, 3, 2, 16, 0);
        wait_idle(40, "job_2x3x2");

        // m == 1: every issue is both first and last, done at 20
        launch(4, 1, 4, 20, 0);
        wait_idle(40, "job_m1");

        // Illegal dims: err at cycle 1, nothing issued
        launch(0, 2, 2, 0, 0);
        wait_idle(10, "err_n0");
        launch(2, 2, 33, 0, 0);
        wait_idle(10, "err_q33");
        repeat (3) @(posedge clk);
        #1;

        // Abort during cycle 7 of a 2x3*3x2 job, then restart immediately
        launch(2, 3, 2, 16, 7);
        repeat (6) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        prod_q.delete();
        chk("abort_idle", 64'({busy, rd_en}), 64'(0));
        launch(2, 3, 2, 16, 0);
        wait_idle(40, "job_after_abort");

        // start and dims toggled mid-job: original 3x2*2x3 job unaffected, done at 22
        launch(3, 2, 3, 22, 0);
        start = 1'b1;
        dim_n = DIM_W'(5);
        dim_m = DIM_W'(5);
        dim_q = DIM_W'(0);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle(40, "job_midjob_ignore");

        // Full-size job, done at 32772
        launch(32, 32, 32, 32772, 0);
        wait_idle(32800, "job_32");

        // Quiet period: any stray issue/write/event is flagged by the monitor
        repeat (10) @(posedge clk);
        #1;
        chk("final_leftover", 64'(exp_iss.size() + exp_wr.size() + ev_q.size() + prod_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
